// File: rtl/uart_alu_engine_if.sv
// Byte stream bundle between the UART receiver/transmitter and the ALU engine.
interface uart_alu_engine_if;
    logic [7:0] REC_BYTE;
    logic       RECEIVED;
    logic [7:0] TX_BYTE;
    logic       TX_VALID;
    logic       TX_READY;
    logic       BUSY;
    logic       DROPPED;

    modport master (
        output REC_BYTE, RECEIVED, TX_READY,
        input  TX_BYTE, TX_VALID, BUSY, DROPPED
    );

    modport slave (
        input  REC_BYTE, RECEIVED, TX_READY,
        output TX_BYTE, TX_VALID, BUSY, DROPPED
    );
endinterface

// File: rtl/uart_alu_engine.sv
// Byte-serial ADD/SUB/NIB engine: opcode + two LE operands in, result bytes + flags out.
// Optional inter-byte gap timeout enabled by defining UART_ALU_TIMEOUT_EN.
module uart_alu_engine #(
    parameter int OPERAND_BYTES  = 2,
    parameter int TIMEOUT_CYCLES = 1200000
) (
    input logic              iCE_CLK,
    input logic              RST,
    uart_alu_engine_if.slave bus
);
    localparam int N  = OPERAND_BYTES;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [2:0] {IDLE, GET_A, GET_B, COMPUTE, SEND, SEND_FLAGS} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_NIB} op_t;

    state_t          state;
    op_t             op;
    logic [IW-1:0]   idx;
    logic            carry;
    logic            zero_acc;
    logic [N-1:0][7:0] a_buf, b_buf, r_buf;
    logic [7:0]      tx_byte;
    logic [7:0]      flags;
    logic            tx_valid;
    logic            dropped;

    logic [7:0]      b_eff;
    logic [8:0]      sum;
    logic [3:0]      nib;
    logic [7:0]      r_byte;
    logic [7:0]      flags_next;

`ifdef UART_ALU_TIMEOUT_EN
    logic [31:0]     gap;
    logic            gap_hit;
    assign gap_hit = (gap == 32'(TIMEOUT_CYCLES - 1));
`endif

    // SUB is A + ~B + 1, so the B path is inverted and carry seeded with 1.
    always_comb begin
        b_eff  = (op == OP_SUB) ? ~b_buf[idx] : b_buf[idx];
        sum    = {1'b0, a_buf[idx]} + {1'b0, b_eff} + {8'd0, carry};
        nib    = a_buf[idx][3:0] + a_buf[idx][7:4];
        r_byte = (op == OP_NIB) ? {nib, nib} : sum[7:0];
        flags_next    = 8'h00;
        flags_next[0] = (op == OP_SUB) ? ~sum[8] : sum[8];
        flags_next[1] = zero_acc && (r_byte == 8'h00);
        flags_next[2] = (a_buf[idx][7] == b_eff[7]) && (r_byte[7] != a_buf[idx][7]);
    end

    always_ff @(posedge iCE_CLK) begin
        if (RST) begin
            state    <= IDLE;
            op       <= OP_ADD;
            idx      <= '0;
            carry    <= 1'b0;
            zero_acc <= 1'b1;
            a_buf    <= '0;
            b_buf    <= '0;
            r_buf    <= '0;
            tx_byte  <= 8'h00;
            flags    <= 8'h00;
            tx_valid <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            dropped <= 1'b0;
            case (state)
                IDLE: begin
                    tx_valid <= 1'b0;
                    if (bus.RECEIVED) begin
                        idx      <= '0;
                        zero_acc <= 1'b1;
                        case (bus.REC_BYTE)
                            8'h00: begin op <= OP_ADD; carry <= 1'b0; state <= GET_A; end
                            8'h01: begin op <= OP_SUB; carry <= 1'b1; state <= GET_A; end
                            8'h02: begin op <= OP_NIB; carry <= 1'b0; state <= GET_A; end
                            default: begin
                                tx_byte  <= 8'hEE;
                                tx_valid <= 1'b1;
                                state    <= SEND_FLAGS;
                            end
                        endcase
                    end
                end
                GET_A: begin
                    if (bus.RECEIVED) begin
                        a_buf[idx] <= bus.REC_BYTE;
                        if (idx == LAST) begin
                            idx   <= '0;
                            state <= (op == OP_NIB) ? COMPUTE : GET_B;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
`ifdef UART_ALU_TIMEOUT_EN
                    else if (gap_hit) begin
                        dropped <= 1'b1;
                        state   <= IDLE;
                    end
`endif
                end
                GET_B: begin
                    if (bus.RECEIVED) begin
                        b_buf[idx] <= bus.REC_BYTE;
                        if (idx == LAST) begin
                            idx   <= '0;
                            state <= COMPUTE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
`ifdef UART_ALU_TIMEOUT_EN
                    else if (gap_hit) begin
                        dropped <= 1'b1;
                        state   <= IDLE;
                    end
`endif
                end
                COMPUTE: begin
                    dropped    <= bus.RECEIVED;
                    r_buf[idx] <= r_byte;
                    carry      <= sum[8];
                    zero_acc   <= zero_acc && (r_byte == 8'h00);
                    if (idx == LAST) begin
                        // With one-byte operands R[0] is still in flight this cycle.
                        tx_byte  <= (idx == '0) ? r_byte : r_buf[0];
                        tx_valid <= 1'b1;
                        flags    <= flags_next;
                        idx      <= '0;
                        state    <= SEND;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                SEND: begin
                    dropped <= bus.RECEIVED;
                    if (bus.TX_READY) begin
                        if (idx == LAST) begin
                            if (op == OP_NIB) begin
                                tx_valid <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                tx_byte <= flags;
                                state   <= SEND_FLAGS;
                            end
                        end else begin
                            tx_byte <= r_buf[idx + 1'b1];
                            idx     <= idx + 1'b1;
                        end
                    end
                end
                SEND_FLAGS: begin
                    dropped <= bus.RECEIVED;
                    if (bus.TX_READY) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_ALU_TIMEOUT_EN
    always_ff @(posedge iCE_CLK) begin
        if (RST)
            gap <= '0;
        else if (bus.RECEIVED)
            gap <= '0;
        else if (state == GET_A || state == GET_B)
            gap <= gap_hit ? '0 : gap + 32'd1;
    end
`endif

    assign bus.TX_BYTE  = tx_byte;
    assign bus.TX_VALID = tx_valid;
    assign bus.BUSY     = (state != IDLE);
    assign bus.DROPPED  = dropped;
endmodule

// File: tb/tb_uart_alu_engine.sv
// Directed bench for uart_alu_engine with OPERAND_BYTES=2.
module tb_uart_alu_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   drops  = 0;
    logic [7:0] txq[$];

    uart_alu_engine_if bus ();

    uart_alu_engine #(.OPERAND_BYTES(2), .TIMEOUT_CYCLES(50)) dut (
        .iCE_CLK (clk),
        .RST     (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Transfers and drop pulses are observed mid-cycle, before the next edge.
    always @(negedge clk) begin
        if (bus.TX_VALID && bus.TX_READY) txq.push_back(bus.TX_BYTE);
        if (bus.DROPPED) drops++;
    end

    function automatic logic [39:0] packq();
        logic [39:0] p;
        p = '0;
        p[39:32] = 8'(txq.size());
        for (int i = 0; i < 4 && i < txq.size(); i++) p[31-8*i -: 8] = txq[i];
        return p;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        bus.REC_BYTE = b;
        bus.RECEIVED = 1'b1;
        @(posedge clk); #1;
        bus.RECEIVED = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.BUSY && n < 200) begin @(posedge clk); #1; n++; end
        if (bus.BUSY) begin
            errors++; checks++;
            $display("FAIL wait_idle: BUSY still 1 after %0d cycles, required 0", n);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.TX_VALID && n < 200) begin @(posedge clk); #1; n++; end
        if (!bus.TX_VALID) begin
            errors++; checks++;
            $display("FAIL %s: TX_VALID never rose, required 1", name);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.TX_BYTE, bus.TX_VALID, bus.BUSY, bus.DROPPED} !== 11'h000) begin
            errors++;
            $display("FAIL reset: TX_BYTE=%h TX_VALID=%b BUSY=%b DROPPED=%b, required 00 0 0 0",
                     bus.TX_BYTE, bus.TX_VALID, bus.BUSY, bus.DROPPED);
        end
    endtask

    task automatic test_add();
        int lat;
        txq.delete();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12); send_byte(8'h01); send_byte(8'h00);
        // Now one cycle after the final strobe; TX_VALID expected OPERAND_BYTES+1 cycles after it.
        lat = 1;
        while (!bus.TX_VALID && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat !== 3) begin
            errors++; $display("FAIL add_latency: got %0d cycles, required 3", lat);
        end
        wait_idle();
        checks++;
        if (packq() !== {8'd3, 8'h00, 8'h13, 8'h00, 8'h00}) begin
            errors++; $display("FAIL add_12ff_0001: got %h, required 0300130000", packq());
        end
        checks++;
        if (bus.BUSY !== 1'b0 || bus.TX_VALID !== 1'b0) begin
            errors++; $display("FAIL add_idle: BUSY=%b TX_VALID=%b, required 0 0", bus.BUSY, bus.TX_VALID);
        end
        txq.delete();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h01); send_byte(8'h00);
        wait_idle();
        checks++;
        if (packq() !== {8'd3, 8'h00, 8'h00, 8'h03, 8'h00}) begin
            errors++; $display("FAIL add_carry_zero: got %h, required 0300000300", packq());
        end
        txq.delete();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h7F); send_byte(8'h01); send_byte(8'h00);
        wait_idle();
        checks++;
        if (packq() !== {8'd3, 8'h00, 8'h80, 8'h04, 8'h00}) begin
            errors++; $display("FAIL add_overflow: got %h, required 0300800400", packq());
        end
    endtask

    task automatic test_sub();
        txq.delete();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        wait_idle();
        checks++;
        if (packq() !== {8'd3, 8'hFF, 8'hFF, 8'h01, 8'h00}) begin
            errors++; $display("FAIL sub_borrow: got %h, required 03ffff0100", packq());
        end
        txq.delete();
        send_byte(8'h01); send_byte(8'h34); send_byte(8'h12); send_byte(8'h34); send_byte(8'h12);
        wait_idle();
        checks++;
        if (packq() !== {8'd3, 8'h00, 8'h00, 8'h02, 8'h00}) begin
            errors++; $display("FAIL sub_equal: got %h, required 0300000200", packq());
        end
    endtask

    task automatic test_bad_opcode();
        txq.delete();
        send_byte(8'h05);
        wait_idle();
        checks++;
        if (packq() !== {8'd1, 8'hEE, 8'h00, 8'h00, 8'h00}) begin
            errors++; $display("FAIL bad_opcode: got %h, required 01ee000000", packq());
        end
    endtask

    task automatic test_nib_hold();
        txq.delete();
        bus.TX_READY = 1'b0;
        send_byte(8'h02); send_byte(8'h43); send_byte(8'h9A);
        wait_valid("nib_valid");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.TX_VALID !== 1'b1 || bus.TX_BYTE !== 8'h77) begin
                errors++;
                $display("FAIL nib_hold[%0d]: TX_VALID=%b TX_BYTE=%h, required 1 77", i, bus.TX_VALID, bus.TX_BYTE);
            end
        end
        bus.TX_READY = 1'b1;
        wait_idle();
        checks++;
        if (packq() !== {8'd2, 8'h77, 8'h33, 8'h00, 8'h00}) begin
            errors++; $display("FAIL nib_stream: got %h, required 0277330000", packq());
        end
    endtask

    task automatic test_drop_in_send();
        int d0;
        txq.delete();
        bus.TX_READY = 1'b0;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12); send_byte(8'h01); send_byte(8'h00);
        wait_valid("drop_valid");
        d0 = drops;
        send_byte(8'h00);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (drops - d0 !== 1 || bus.BUSY !== 1'b1 || bus.TX_BYTE !== 8'h00) begin
            errors++;
            $display("FAIL drop_pulse: drops=%0d BUSY=%b TX_BYTE=%h, required 1 1 00", drops - d0, bus.BUSY, bus.TX_BYTE);
        end
        bus.TX_READY = 1'b1;
        wait_idle();
        checks++;
        if (packq() !== {8'd3, 8'h00, 8'h13, 8'h00, 8'h00}) begin
            errors++; $display("FAIL drop_stream: got %h, required 0300130000", packq());
        end
    endtask

    task automatic test_reset_mid_frame();
        txq.delete();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.TX_BYTE, bus.TX_VALID, bus.BUSY, bus.DROPPED} !== 11'h000) begin
            errors++;
            $display("FAIL rst_mid: TX_BYTE=%h TX_VALID=%b BUSY=%b DROPPED=%b, required 00 0 0 0",
                     bus.TX_BYTE, bus.TX_VALID, bus.BUSY, bus.DROPPED);
        end
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (txq.size() !== 0 || bus.BUSY !== 1'b0) begin
            errors++; $display("FAIL rst_quiet: tx count=%0d BUSY=%b, required 0 0", txq.size(), bus.BUSY);
        end
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
        wait_idle();
        checks++;
        if (packq() !== {8'd3, 8'h03, 8'h00, 8'h00, 8'h00}) begin
            errors++; $display("FAIL rst_fresh: got %h, required 0303000000", packq());
        end
    endtask

`ifdef UART_ALU_TIMEOUT_EN
    task automatic test_timeout();
        int d0;
        txq.delete();
        d0 = drops;
        send_byte(8'h00); send_byte(8'hFF);
        repeat (55) @(posedge clk);
        #1;
        checks++;
        if (drops - d0 !== 1 || bus.BUSY !== 1'b0 || txq.size() !== 0) begin
            errors++;
            $display("FAIL timeout: drops=%0d BUSY=%b tx count=%0d, required 1 0 0", drops - d0, bus.BUSY, txq.size());
        end
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12); send_byte(8'h01); send_byte(8'h00);
        wait_idle();
        checks++;
        if (packq() !== {8'd3, 8'h00, 8'h13, 8'h00, 8'h00}) begin
            errors++; $display("FAIL timeout_next: got %h, required 0300130000", packq());
        end
    endtask
`endif

    initial begin
        bus.REC_BYTE = 8'h00;
        bus.RECEIVED = 1'b0;
        bus.TX_READY = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_add();
        test_sub();
        test_bad_opcode();
        test_nib_hold();
        test_drop_in_send();
        test_reset_mid_frame();
`ifdef UART_ALU_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
